// File: rtl/wide_alu_sequencer.sv
// Sequences an external 8-bit ALU to run 16-bit ADD/SHL/SHR in two byte steps.
// Optional GT16 compare (three steps) is compiled in when WIDE_ALU_GT16_EN is defined.
module wide_alu_sequencer (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        carry_out,
   output logic        alu_ritype,
   output logic [2:0]  alu_op,
   output logic [7:0]  alu_r1,
   output logic [7:0]  alu_r2,
   output logic        alu_shift_dir,
   output logic        alu_carry_in,
   output logic        alu_overflow_in,
   input  logic [7:0]  alu_out,
   input  logic        alu_carry,
   input  logic        alu_overflow
);

   typedef enum logic [2:0] {IDLE, STEP1, STEP2, STEP3, DONE} state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SHL = 2'b01;
   localparam logic [1:0] OP_SHR = 2'b10;
   localparam logic [1:0] OP_GT  = 2'b11;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] a_q, a_d, b_q, b_d;
   logic [7:0]  stage_q, stage_d;
   logic [15:0] result_q, result_d;
   logic        carry_out_q, carry_out_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic [2:0]  alu_op_q, alu_op_d;
   logic [7:0]  alu_r1_q, alu_r1_d, alu_r2_q, alu_r2_d;
   logic        alu_shift_dir_q, alu_shift_dir_d;
   logic        alu_carry_in_q, alu_carry_in_d;
   logic        alu_overflow_in_q, alu_overflow_in_d;
`ifdef WIDE_ALU_GT16_EN
   logic        g_hi_q, g_hi_d, l_hi_q, l_hi_d;
`endif

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      stage_d     = stage_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
`ifdef WIDE_ALU_GT16_EN
      g_hi_d      = g_hi_q;
      l_hi_d      = l_hi_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            state_d = STEP1;
            op_d    = op;
            a_d     = a;
            b_d     = b;
            if (op == OP_GT) carry_out_d = 1'b0;
         end
         STEP1: begin
            stage_d = alu_out;
            state_d = STEP2;
            if (op_q == OP_GT) begin
`ifdef WIDE_ALU_GT16_EN
               g_hi_d   = alu_out[0];
`else
               result_d = 16'h0000;
               state_d  = DONE;
`endif
            end
         end
         STEP2: begin
            state_d = DONE;
            case (op_q)
               OP_ADD: begin result_d = {alu_out, stage_q}; carry_out_d = alu_overflow; end
               OP_SHL: begin result_d = {alu_out, stage_q}; carry_out_d = a_q[15]; end
               // right shift walks the high byte first, so the staged byte is the top half
               OP_SHR: begin result_d = {stage_q, alu_out}; carry_out_d = a_q[0]; end
               default: begin
`ifdef WIDE_ALU_GT16_EN
                  l_hi_d  = alu_out[0];
                  state_d = STEP3;
`endif
               end
            endcase
         end
`ifdef WIDE_ALU_GT16_EN
         STEP3: begin
            result_d = {15'b0, g_hi_q | (~l_hi_q & alu_out[0])};
            state_d  = DONE;
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);

      // ALU drive is registered: computed for the state being entered
      alu_op_d          = 3'b000;
      alu_r1_d          = 8'h00;
      alu_r2_d          = 8'h00;
      alu_shift_dir_d   = 1'b0;
      alu_carry_in_d    = 1'b0;
      alu_overflow_in_d = 1'b0;
      case (state_d)
         STEP1: case (op_d)
            OP_ADD: begin alu_op_d = 3'b001; alu_r1_d = a_d[7:0]; alu_r2_d = b_d[7:0]; end
            OP_SHL: begin alu_op_d = 3'b101; alu_r1_d = a_d[7:0]; end
            OP_SHR: begin
               alu_op_d = 3'b101; alu_shift_dir_d = 1'b1;
               alu_r1_d = a_d[15:8]; alu_r2_d = 8'd1;
            end
`ifdef WIDE_ALU_GT16_EN
            OP_GT:  begin alu_op_d = 3'b110; alu_r1_d = a_d[15:8]; alu_r2_d = b_d[15:8]; end
`endif
            default: ;
         endcase
         STEP2: case (op_d)
            OP_ADD: begin
               alu_op_d = 3'b001; alu_r1_d = a_d[15:8]; alu_r2_d = b_d[15:8];
               alu_overflow_in_d = alu_overflow;
            end
            OP_SHL: begin
               alu_op_d = 3'b101; alu_r1_d = a_d[15:8]; alu_r2_d = 8'd1;
               alu_carry_in_d = alu_carry;
            end
            OP_SHR: begin
               alu_op_d = 3'b101; alu_shift_dir_d = 1'b1; alu_r1_d = a_d[7:0];
               alu_carry_in_d = alu_carry;
            end
`ifdef WIDE_ALU_GT16_EN
            OP_GT:  begin alu_op_d = 3'b110; alu_r1_d = b_d[15:8]; alu_r2_d = a_d[15:8]; end
`endif
            default: ;
         endcase
`ifdef WIDE_ALU_GT16_EN
         STEP3: begin alu_op_d = 3'b110; alu_r1_d = a_d[7:0]; alu_r2_d = b_d[7:0]; end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q           <= IDLE;
         op_q              <= 2'b00;
         a_q               <= 16'h0000;
         b_q               <= 16'h0000;
         stage_q           <= 8'h00;
         result_q          <= 16'h0000;
         carry_out_q       <= 1'b0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         alu_op_q          <= 3'b000;
         alu_r1_q          <= 8'h00;
         alu_r2_q          <= 8'h00;
         alu_shift_dir_q   <= 1'b0;
         alu_carry_in_q    <= 1'b0;
         alu_overflow_in_q <= 1'b0;
`ifdef WIDE_ALU_GT16_EN
         g_hi_q            <= 1'b0;
         l_hi_q            <= 1'b0;
`endif
      end else begin
         state_q           <= state_d;
         op_q              <= op_d;
         a_q               <= a_d;
         b_q               <= b_d;
         stage_q           <= stage_d;
         result_q          <= result_d;
         carry_out_q       <= carry_out_d;
         busy_q            <= busy_d;
         done_q            <= done_d;
         alu_op_q          <= alu_op_d;
         alu_r1_q          <= alu_r1_d;
         alu_r2_q          <= alu_r2_d;
         alu_shift_dir_q   <= alu_shift_dir_d;
         alu_carry_in_q    <= alu_carry_in_d;
         alu_overflow_in_q <= alu_overflow_in_d;
`ifdef WIDE_ALU_GT16_EN
         g_hi_q            <= g_hi_d;
         l_hi_q            <= l_hi_d;
`endif
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign result          = result_q;
   assign carry_out       = carry_out_q;
   assign alu_ritype      = 1'b0;
   assign alu_op          = alu_op_q;
   assign alu_r1          = alu_r1_q;
   assign alu_r2          = alu_r2_q;
   assign alu_shift_dir   = alu_shift_dir_q;
   assign alu_carry_in    = alu_carry_in_q;
   assign alu_overflow_in = alu_overflow_in_q;

endmodule

// File: tb/tb_wide_alu_sequencer.sv
// Self-checking bench for wide_alu_sequencer: an 8-bit ALU model answers the
// sequencer, and 16-bit results are compared against whole-word arithmetic.
module tb_wide_alu_sequencer;

   logic        Clk = 1'b0;
   logic        Reset, start;
   logic [1:0]  op;
   logic [15:0] a, b;
   logic        busy, done, carry_out;
   logic [15:0] result;
   logic        alu_ritype, alu_shift_dir, alu_carry_in, alu_overflow_in;
   logic [2:0]  alu_op;
   logic [7:0]  alu_r1, alu_r2, alu_out;
   logic        alu_carry, alu_overflow;
   logic [8:0]  sum;

   int checks = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   wide_alu_sequencer dut (
      .Clk(Clk), .Reset(Reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .carry_out(carry_out),
      .alu_ritype(alu_ritype), .alu_op(alu_op), .alu_r1(alu_r1), .alu_r2(alu_r2),
      .alu_shift_dir(alu_shift_dir), .alu_carry_in(alu_carry_in),
      .alu_overflow_in(alu_overflow_in), .alu_out(alu_out),
      .alu_carry(alu_carry), .alu_overflow(alu_overflow)
   );

   // external 8-bit ALU: add with carry, byte shift with fill, unsigned compare
   always_comb begin
      alu_out = 8'h00; alu_carry = 1'b0; alu_overflow = 1'b0; sum = 9'h000;
      case (alu_op)
         3'b001: begin
            sum = {1'b0, alu_r1} + {1'b0, alu_r2} + {8'h00, alu_overflow_in};
            alu_out = sum[7:0]; alu_overflow = sum[8];
         end
         3'b101: if (!alu_shift_dir) begin
            alu_out = {alu_r1[6:0], alu_carry_in}; alu_carry = alu_r1[7];
         end else begin
            alu_out = {(alu_r2[0] ? alu_r1[7] : alu_carry_in), alu_r1[7:1]};
            alu_carry = alu_r1[0];
         end
         3'b110: alu_out = {7'h00, alu_r1 > alu_r2};
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {carry_out, result} of the whole 16-bit operation
   function automatic logic [16:0] ref_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
      case (o)
         2'b00:   return {1'b0, x} + {1'b0, y};
         2'b01:   return {x[15], x << 1};
         2'b10:   return {x[0], $signed(x) >>> 1};
`ifdef WIDE_ALU_GT16_EN
         default: return {16'h0000, x > y};
`else
         default: return 17'h00000;
`endif
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] o);
`ifdef WIDE_ALU_GT16_EN
      return (o == 2'b11) ? 3 : 2;
`else
      return (o == 2'b11) ? 1 : 2;
`endif
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
      logic [16:0] exp_v;
      logic [15:0] prev_res;
      logic        prev_c;
      logic [8:0]  lo_sum;
      int          n;
      exp_v    = ref_op(o, x, y);
      prev_res = result;
      prev_c   = (o == 2'b11) ? 1'b0 : carry_out;
      lo_sum   = {1'b0, x[7:0]} + {1'b0, y[7:0]};
      @(negedge Clk);
      check("idle_busy", busy, 1'b0);
      check("idle_alu_op", alu_op, 3'b000);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge Clk);
      start = 1'b0; a = ~x; b = ~y;
      n = 0;
      while (done !== 1'b1 && n < 8) begin
         check("step_busy", busy, 1'b1);
         check("step_result_hold", result, prev_res);
         check("step_carry_hold", carry_out, prev_c);
         check("ritype", alu_ritype, 1'b0);
         if (o == 2'b00 && n == 1) check("add_ovf_in", alu_overflow_in, lo_sum[8]);
         @(negedge Clk);
         n++;
      end
      check("done_seen", done, 1'b1);
      check("latency", n, ref_lat(o));
      check("result", result, exp_v[15:0]);
      check("carry_out", carry_out, exp_v[16]);
      check("done_busy", busy, 1'b1);
      check("done_alu_op", alu_op, 3'b000);
      @(negedge Clk);
      check("done_one_cycle", done, 1'b0);
      check("back_idle", busy, 1'b0);
      check("result_hold", result, exp_v[15:0]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int pulses;
      logic [16:0] ev;
      Reset = 1'b1; start = 1'b0; op = 2'b00; a = 16'h0; b = 16'h0;
      repeat (2) @(negedge Clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_result", result, 16'h0000);
      check("rst_carry", carry_out, 1'b0);
      check("rst_alu_op", alu_op, 3'b000);
      Reset = 1'b0;

      run_op(2'b00, 16'h00FF, 16'h0001);
      run_op(2'b00, 16'hFFFF, 16'h0001);
      run_op(2'b01, 16'h8181, 16'h0000);
      run_op(2'b10, 16'h8101, 16'h0000);
      run_op(2'b11, 16'h0102, 16'h0101);
      run_op(2'b11, 16'h0101, 16'h0201);
      run_op(2'b00, 16'h8000, 16'h8000);
      run_op(2'b10, 16'h7FFE, 16'h0000);

      for (int i = 0; i < 24; i++)
         run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));

      // start held high: one accept per IDLE visit, one done per accept
      a = 16'($urandom); b = 16'($urandom);
      ev = ref_op(2'b00, a, b);
      pulses = 0;
      @(negedge Clk);
      start = 1'b1; op = 2'b00;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clk);
         if (done === 1'b1) begin
            pulses++;
            check("held_result", result, ev[15:0]);
            check("held_carry", carry_out, ev[16]);
         end
         if (i == 11) start = 1'b0;
      end
      check("held_done_pulses", pulses, 3);
      @(negedge Clk);
      check("held_idle", busy, 1'b0);

      // reset in STEP1 aborts with no done pulse
      run_op(2'b00, 16'h1234, 16'h1111);
      @(negedge Clk);
      start = 1'b1; op = 2'b00; a = 16'h0F0F; b = 16'h0101;
      @(negedge Clk);
      start = 1'b0;
      check("pre_rst_busy", busy, 1'b1);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_result", result, 16'h0000);
      check("abort_carry", carry_out, 1'b0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         if (done === 1'b1) pulses++;
      end
      check("abort_no_done", pulses, 0);

      // reset wins over start
      Reset = 1'b1; start = 1'b1;
      @(negedge Clk);
      check("rst_prio_busy", busy, 1'b0);
      Reset = 1'b0; start = 1'b0;

      run_op(2'b01, 16'h4001, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wide_alu_sequencer.md
WIDE_ALU_SEQUENCER -- requirements
Module: wide_alu_sequencer

Interface
REQ-001 SHALL have ports: Clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  request; accepted only when busy=0 on a rising Clk edge.
REQ-004 SHALL have ports: op  in  2  00=ADD16, 01=SHL16, 10=SHR16, 11=GT16 (only with the Configuration macro defined).
REQ-005 SHALL have ports: a, b  in  16  operands, latched on accept.
REQ-006 SHALL have ports: busy  out  1; done  out  1; result  out  16; carry_out  out  1.
REQ-007 SHALL have ALU-facing ports: alu_ritype out 1, alu_op out 3, alu_r1 out 8, alu_r2 out 8, alu_shift_dir out 1, alu_carry_in out 1, alu_overflow_in out 1.
REQ-008 SHALL have ALU-return ports: alu_out in 8, alu_carry in 1, alu_overflow in 1.

Function
REQ-009 SHALL implement FSM states IDLE, STEP1, STEP2, STEP3, DONE.
REQ-010 SHALL, in IDLE with start=1, latch a, b, op and go to STEP1; start is ignored in every other state.
REQ-011 SHALL set busy=1 in STEP1..DONE and busy=0 in IDLE.
REQ-012 SHALL drive alu_ritype=0 at all times, and drive alu_op=000 with all other ALU outputs 0 in IDLE and DONE.
REQ-013 ADD16 SHALL run two steps. STEP1: alu_op=001, r1=a[7:0], r2=b[7:0], overflow_in=0. STEP2: alu_op=001, r1=a[15:8], r2=b[15:8], overflow_in=alu_overflow registered at the end of STEP1. carry_out=alu_overflow registered at the end of STEP2.
REQ-014 SHL16 SHALL run two steps, low byte first. Both steps: alu_op=101, shift_dir=0. STEP1: r1=a[7:0], r2=8'd0. STEP2: r1=a[15:8], r2=8'd1, carry_in=alu_carry registered at the end of STEP1. carry_out=a[15].
REQ-015 SHR16 SHALL run two steps, high byte first (arithmetic shift). Both steps: alu_op=101, shift_dir=1. STEP1: r1=a[15:8], r2=8'd1. STEP2: r1=a[7:0], r2=8'd0, carry_in=alu_carry registered at the end of STEP1. carry_out=a[0].
REQ-016 SHALL write each step's alu_out into the matching result byte at the end of that step.
REQ-017 SHALL go from the last step to DONE, assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-018 Latency: for an accept at edge k, done=1 in the cycle after edge k+2 for two-step ops and after edge k+3 for GT16.
REQ-019 SHALL hold result and carry_out stable from DONE until the next accept; both remain unchanged during STEP states.
REQ-020 SHALL clear carry_out to 0 on accept of GT16 or of op=11.

Reset
REQ-021 Reset=1 SHALL force IDLE, busy=0, done=0, result=16'h0000, carry_out=0, and all internal carry registers to 0 at the next edge.
REQ-022 Reset SHALL take priority over start and over any in-flight step.
REQ-023 Reset in any state SHALL abort the operation with no done pulse.

Configuration
REQ-024 Macro WIDE_ALU_GT16_EN SHALL, when defined, enable GT16 as a three-step op using alu_op=110.
REQ-025 GT16 steps SHALL be: STEP1 r1=a[15:8], r2=b[15:8] -> g_hi; STEP2 r1=b[15:8], r2=a[15:8] -> l_hi; STEP3 r1=a[7:0], r2=b[7:0] -> g_lo.
REQ-026 GT16 SHALL set result={15'b0, g_hi | (~l_hi & g_lo)} (unsigned), with carry_out=0.
REQ-027 With the macro undefined, op=11 SHALL be accepted and go IDLE->STEP1->DONE with ALU outputs idle and result=16'h0000; STEP3 SHALL not be reachable.

Verification
REQ-028 ADD16 a=16'h00FF, b=16'h0001 -> alu_overflow_in=1 in STEP2; result=16'h0100, carry_out=0; done 3 cycles after accept.
REQ-029 ADD16 a=16'hFFFF, b=16'h0001 -> result=16'h0000, carry_out=1.
REQ-030 SHL16 a=16'h8181 -> result=16'h0302, carry_out=1; SHR16 a=16'h8101 -> result=16'hC080, carry_out=1.
REQ-031 Macro defined: GT16 a=16'h0102, b=16'h0101 -> result=16'h0001; GT16 a=16'h0101, b=16'h0201 -> result=16'h0000; done 4 cycles after accept. Macro undefined: op=11 -> result=16'h0000, done 2 cycles after accept.
REQ-032 start=1 held through an ADD16 -> exactly one accept per IDLE visit, with done pulsing once each.
REQ-033 Reset=1 during STEP1 -> next cycle IDLE, busy=0, result=16'h0000, and no done pulse.
